// File: rtl/i2s_uart_uplink.sv
// I2S-slave capture -> 8-bit unsigned mono byte FIFO -> 8N1 UART transmitter.
// All I2S pins are asynchronous and double-flopped onto clk.
// Optional build macro: I2S_UPLINK_STEREO_MIX_EN (mix left+right instead of left only).
module i2s_uart_uplink #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned SAMPLE_BITS  = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture_en,
  input  logic                          i2s_bck,
  input  logic                          i2s_ws,
  input  logic                          i2s_data,
  output logic                          uart_tx,
  output logic                          sample_strobe,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned CW   = $clog2(SAMPLE_BITS + 1);
  localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  logic [1:0]             bck_sync_q, bck_sync_d;
  logic [1:0]             ws_sync_q, ws_sync_d;
  logic [1:0]             data_sync_q, data_sync_d;
  logic                   bck_prev_q, bck_prev_d;
  logic                   ws_last_q, ws_last_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shl_q, shl_d;
`ifdef I2S_UPLINK_STEREO_MIX_EN
  logic [SAMPLE_BITS-1:0] shr_q, shr_d;
  logic                   left_ok_q, left_ok_d;
  logic [SAMPLE_BITS:0]   mix_sum;
`endif
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   strobe_q, strobe_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             mem [FIFO_DEPTH];

  logic                   bck_rise, ws_edge, word_full;
  logic                   push_req, push_ok, pop, fifo_full, fifo_empty;
  logic [7:0]             push_byte;

  tx_state_e              tx_state_q;
  logic                   tx_q;
  logic [CNTW-1:0]        clk_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             tx_shift_q;

  assign bck_rise   = bck_sync_q[1] & ~bck_prev_q;
  assign ws_edge    = bck_rise && (ws_sync_q[1] != ws_last_q);
  assign word_full  = (bit_cnt_q == CW'(SAMPLE_BITS));
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = (tx_state_q == StIdle) && !fifo_empty;

  // Synchronizers and word framing: shift MSB-first until the slot is full.
  always_comb begin
    bck_sync_d  = {bck_sync_q[0], i2s_bck};
    ws_sync_d   = {ws_sync_q[0], i2s_ws};
    data_sync_d = {data_sync_q[0], i2s_data};
    bck_prev_d  = bck_sync_q[1];
    bit_cnt_d   = bit_cnt_q;
    ws_last_d   = ws_last_q;
    shl_d       = shl_q;
`ifdef I2S_UPLINK_STEREO_MIX_EN
    shr_d       = shr_q;
    left_ok_d   = left_ok_q;
`endif
    if (bck_rise) begin
      if (ws_edge) begin
        // The bit on a boundary rise is the previous slot's tail; drop it.
        bit_cnt_d = '0;
        ws_last_d = ws_sync_q[1];
`ifdef I2S_UPLINK_STEREO_MIX_EN
        left_ok_d = !ws_last_q && word_full;
`endif
      end else if (!word_full) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (!ws_last_q) shl_d = {shl_q[SAMPLE_BITS-2:0], data_sync_q[1]};
`ifdef I2S_UPLINK_STEREO_MIX_EN
        else            shr_d = {shr_q[SAMPLE_BITS-2:0], data_sync_q[1]};
`endif
      end
    end
  end

  // Byte formation: signed PCM top byte flipped to offset-binary.
  always_comb begin
`ifdef I2S_UPLINK_STEREO_MIX_EN
    mix_sum   = {shl_q[SAMPLE_BITS-1], shl_q} + {shr_q[SAMPLE_BITS-1], shr_q};
    // Top 8 bits of (sum >>> 1) are sum[SAMPLE_BITS -: 8].
    push_byte = 8'(mix_sum >> (SAMPLE_BITS - 7)) ^ 8'h80;
    push_req  = ws_edge && ws_last_q && word_full && left_ok_q;
`else
    push_byte = shl_q[SAMPLE_BITS-1 -: 8] ^ 8'h80;
    push_req  = ws_edge && !ws_last_q && word_full;
`endif
  end

  // FIFO bookkeeping: a pop frees room for a same-cycle push even when full.
  always_comb begin
    push_ok    = push_req && capture_en && (!fifo_full || pop);
    overflow_d = overflow_q | (push_req && capture_en && fifo_full && !pop);
    strobe_d   = push_ok;
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Capture and FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync_q  <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
      bck_prev_q  <= 1'b0;
      ws_last_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shl_q       <= '0;
`ifdef I2S_UPLINK_STEREO_MIX_EN
      shr_q       <= '0;
      left_ok_q   <= 1'b0;
`endif
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      strobe_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bck_sync_q  <= bck_sync_d;
      ws_sync_q   <= ws_sync_d;
      data_sync_q <= data_sync_d;
      bck_prev_q  <= bck_prev_d;
      ws_last_q   <= ws_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shl_q       <= shl_d;
`ifdef I2S_UPLINK_STEREO_MIX_EN
      shr_q       <= shr_d;
      left_ok_q   <= left_ok_d;
`endif
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      strobe_q    <= strobe_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_byte;
  end

  // UART 8N1 transmitter with registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_q       <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      tx_shift_q <= '0;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          tx_q      <= 1'b1;
          clk_cnt_q <= '0;
          if (pop) begin
            tx_shift_q <= mem[rd_ptr_q];
            tx_q       <= 1'b0;
            tx_state_q <= StStart;
          end
        end
        StStart: begin
          if (clk_cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end
        StData: begin
          if (clk_cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= StStop;
            end else begin
              bit_idx_q  <= bit_idx_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end
        StStop: begin
          if (clk_cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q  <= '0;
            tx_state_q <= StIdle;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx       = tx_q;
  assign sample_strobe = strobe_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_i2s_uart_uplink.sv
// Directed bench for i2s_uart_uplink: Philips-format I2S source, scoreboard of
// expected bytes, and a cycle-exact 8N1 frame checker on uart_tx.
`timescale 1ns/1ps
module tb_i2s_uart_uplink;
  localparam int CPB  = 234;
  localparam int HALF = 3;   // clk per bck phase
  localparam int SLOT = 17;  // one lead bit plus a 16-bit word per slot

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       capture_en = 1'b1;
  logic       i2s_bck = 1'b0;
  logic       i2s_ws = 1'b0;
  logic       i2s_data = 1'b0;
  logic       uart_tx, sample_strobe, overflow;
  logic [4:0] fifo_level;

  always #5 clk = ~clk;

  i2s_uart_uplink dut (
    .clk           (clk),
    .rst           (rst),
    .capture_en    (capture_en),
    .i2s_bck       (i2s_bck),
    .i2s_ws        (i2s_ws),
    .i2s_data      (i2s_data),
    .uart_tx       (uart_tx),
    .sample_strobe (sample_strobe),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  int         rx_cnt = 0;
  int         strobe_cnt = 0;
  int         tx_low_cnt = 0;
  logic [4:0] max_level = '0;
  logic [4:0] strobe_level = '0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_UPLINK_STEREO_MIX_EN
    int li, ri, s;
    li = $signed(l);
    ri = $signed(r);
    s  = (li + ri) >>> 1;
    exp_byte = 8'((s >>> 8) & 255) ^ 8'h80;
`else
    exp_byte = l[15:8] ^ 8'h80;
`endif
  endfunction

  // Event monitor on the non-active edge.
  always @(negedge clk) begin
    if (sample_strobe === 1'b1) begin
      strobe_cnt   <= strobe_cnt + 1;
      strobe_level <= fifo_level;
    end
    if (uart_tx !== 1'b1) tx_low_cnt <= tx_low_cnt + 1;
    if (fifo_level > max_level) max_level <= fifo_level;
  end

  // One bck period: pins change together while bck is low.
  task automatic bck_cycle(input logic ws, input logic d);
    @(negedge clk);
    i2s_bck  = 1'b0;
    i2s_ws   = ws;
    i2s_data = d;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk);
    i2s_bck = 1'b1;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_slot(input logic ws, input logic [15:0] w);
    for (int r = 0; r < SLOT; r++) begin
      if (r >= 1 && r <= 16) bck_cycle(ws, w[16-r]);
      else bck_cycle(ws, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l);
    send_slot(1'b1, r);
  endtask

  // Short left then short right slot: closes the last frame in either build.
  task automatic send_tail();
    bck_cycle(1'b0, 1'b0);
    bck_cycle(1'b0, 1'b0);
    bck_cycle(1'b1, 1'b0);
    bck_cycle(1'b1, 1'b0);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int n;
    n = 0;
    while (rx_cnt < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, rx_cnt, target);
  endtask

  // UART receiver: every cycle of each frame must match the expected bit.
  initial begin : uart_rx
    logic       prev_tx;
    logic [7:0] exp_b;
    logic [7:0] got;
    logic       want;
    int         err;
    bit         aborted;
    int         k;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_tx = 1'b1;
      end else if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("uart_unexpected_frame", 1, 0);
          exp_b = 8'h00;
        end else begin
          exp_b = exp_q.pop_front();
        end
        err = 0;
        got = '0;
        aborted = 1'b0;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          k = c / CPB;
          if (k == 0) want = 1'b0;
          else if (k == 9) want = 1'b1;
          else want = exp_b[k-1];
          if (uart_tx !== want) err++;
          if (k >= 1 && k <= 8 && (c % CPB) == CPB / 2) got[k-1] = uart_tx;
        end
        if (!aborted) begin
          check("uart_byte", got, exp_b);
          check("uart_bit_timing", err, 0);
          rx_cnt++;
        end
        prev_tx = 1'b1;
      end else begin
        prev_tx = uart_tx;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         s0, low0, n;
    logic [15:0] l;

    // Reset held 5 clk with bck toggling.
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      i2s_bck = ~i2s_bck;
    end
    check("rst_uart_tx", uart_tx, 1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_no_strobe", strobe_cnt, 0);
    @(negedge clk);
    i2s_bck = 1'b0;
    i2s_ws  = 1'b0;
    rst     = 1'b0;
    repeat (10) @(negedge clk);

    // Partial first slot is dropped; next full left word is sent.
    s0 = strobe_cnt;
    for (int r = 0; r < 8; r++) bck_cycle(1'b0, r[0]);
    send_slot(1'b1, 16'hFFFF);
    exp_q.push_back(exp_byte(16'h4000, 16'h2000));
    send_frame(16'h4000, 16'h2000);
    send_tail();
    wait_rx(1, "partial_rx_count");
    check("partial_strobes", strobe_cnt - s0, 1);

    // Single sample 0x1234 / 0xFFFF.
    s0 = strobe_cnt;
    exp_q.push_back(exp_byte(16'h1234, 16'hFFFF));
    send_frame(16'h1234, 16'hFFFF);
    send_tail();
    wait_rx(2, "single_rx_count");
    check("single_strobes", strobe_cnt - s0, 1);
    check("single_level_at_strobe", strobe_level, 1);

    // Sign conversion; right = left so both builds give the same byte.
    s0 = strobe_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    send_frame(16'h8000, 16'h8000);
    send_frame(16'h7FFF, 16'h7FFF);
    send_frame(16'h0000, 16'h0000);
    send_tail();
    wait_rx(5, "sign_rx_count");
    check("sign_strobes", strobe_cnt - s0, 3);

    // Gating: nothing captured while capture_en = 0.
    repeat (5) @(negedge clk);
    s0 = strobe_cnt;
    low0 = tx_low_cnt;
    capture_en = 1'b0;
    send_frame(16'h1100, 16'h1100);
    send_frame(16'h2200, 16'h2200);
    send_frame(16'h3300, 16'h3300);
    send_tail();
    repeat (50) @(negedge clk);
    check("gate_no_strobe", strobe_cnt - s0, 0);
    check("gate_tx_idle", tx_low_cnt - low0, 0);
    check("gate_level", fifo_level, 0);
    capture_en = 1'b1;
    s0 = strobe_cnt;
    exp_q.push_back(8'hDA);
    send_frame(16'h5A00, 16'h5A00);
    send_tail();
    wait_rx(6, "gate_rx_count");
    check("gate_reenable_strobes", strobe_cnt - s0, 1);

    // Overflow: 20 frames much faster than the UART drains.
    s0 = strobe_cnt;
    for (int k = 0; k < 20; k++) begin
      l = {8'(k * 13 + 5), 8'h3C};
      exp_q.push_back(exp_byte(l, l));
      send_frame(l, l);
    end
    send_tail();
    repeat (20) @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_max_level", max_level, 16);
    n = strobe_cnt - s0;
    check("ovf_strobes_dropped", (n >= 17 && n <= 19), 1);
    wait_rx(10, "ovf_rx_count");
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of a frame.
    n = 0;
    while (uart_tx !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_frame_started", uart_tx, 0);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uart_tx", uart_tx, 1);
    check("midrst_fifo_level", fifo_level, 0);
    check("midrst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    low0 = tx_low_cnt;
    repeat (500) @(negedge clk);
    check("midrst_tx_idle", tx_low_cnt - low0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_uart_uplink.md
# i2s_uart_uplink

I2S-slave capture path that receives PCM audio from an external ADC or microphone, reduces each frame to one 8-bit unsigned mono byte, buffers it in a small FIFO, and streams it out as 8N1 UART. It is the reverse direction of the existing playback chain (UART RX → sample FIFO → I2S driver), so the board can record as well as play. The block runs entirely on the 27 MHz system clock and treats all I2S pins as asynchronous inputs.

## Interface
- CLKS_PER_BIT, 234, system clocks per UART bit (27 MHz / 115200).
- SAMPLE_BITS, 16, captured bits per channel word, MSB first; extra bits in a slot are ignored.
- FIFO_DEPTH, 16, byte FIFO depth (power of two).
- clk  in  1  27 MHz system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- capture_en  in  1  1 = push completed samples into the FIFO; 0 = discard them (UART still drains the FIFO).
- i2s_bck  in  1  bit clock from the external master, asynchronous.
- i2s_ws  in  1  word select, 0 = left, 1 = right, asynchronous.
- i2s_data  in  1  serial data, Philips I2S format, asynchronous.
- uart_tx  out  1  8N1 serial output, idle high.
- sample_strobe  out  1  one-cycle pulse when a byte is pushed into the FIFO.
- overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Input conditioning:** two-FF synchronizer on each of bck, ws and data. The bck rising edge is detected from the synchronized bck versus its previous value. All capture actions happen only on a detected bck rise.
- **Word framing:** on each bck rise, compare the synchronized ws with ws_last, the ws value sampled at the previous bck rise.
  - If they differ, this is a word boundary. The current data bit is the last bit of the previous slot and is not captured.
  - At the boundary, the previous slot's word is closed. It is valid only if bit_cnt == SAMPLE_BITS.
  - bit_cnt is then cleared and the channel is set to the new ws.
  - If they are equal and bit_cnt < SAMPLE_BITS, shift data into the channel shift register and increment bit_cnt. Otherwise, ignore the bit.
  - A word closed with bit_cnt < SAMPLE_BITS, for example the first partial slot after reset, is discarded.
- **Sample formation (default):** a valid left word closed at a left→right boundary yields one byte, equal to the word's top 8 bits XOR 0x80 (signed to unsigned). Right words are discarded.
- **Push:** if capture_en = 1, push the byte.
  - If the FIFO is full and no pop occurs in the same cycle, drop the byte, set overflow, and do not pulse sample_strobe.
  - If capture_en = 0, no push, no strobe and no overflow.
- **FIFO:** a push and a pop in the same cycle are both accepted, even when the FIFO is full; fifo_level is then unchanged.
- **UART TX FSM:** states IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is not empty, pop one byte, latch it, and go to START.
  - START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
  - Each state (and each data bit) lasts exactly CLKS_PER_BIT cycles.
  - STOP returns to IDLE, so back-to-back frames have no extra idle gap beyond the one IDLE cycle.
- **Throughput:** sustained input is limited to about 11.5 kHz frames at 115200 baud. Faster sources overflow and drop the newest samples.

## Timing
- **Reset values:** uart_tx = 1, sample_strobe = 0, overflow = 0, fifo_level = 0; FSM in IDLE; bit_cnt = 0; ws_last = 0; shift registers = 0.
- **Reset mid-operation:** an in-flight UART frame is abandoned with uart_tx high on the cycle after rst is sampled, and the FIFO is emptied.
- **Pin-to-detect latency:** a bck rising edge at the pin is detected 3 clk later.
- **bck limits:** bck high and low phases must each be at least 3 clk, so bck is at most 4.5 MHz.
- **Push timing:** the push and sample_strobe occur in the cycle after the boundary bck rise is detected, and fifo_level updates in that same cycle.
- **Pop to start bit:** the pop occurs in IDLE. uart_tx falls on the next cycle.
- **Frame length:** 10 × CLKS_PER_BIT cycles from start-bit fall to end of stop bit.

## Configuration
- **I2S_UPLINK_STEREO_MIX_EN**
  - Defined: capture both slots. At each right→left boundary where both left and right words of that frame are valid, sum them sign-extended to SAMPLE_BITS+1 bits and arithmetic-shift right by 1. The byte is the top 8 bits of that SAMPLE_BITS-bit result XOR 0x80. Pushing happens at the right→left boundary instead of left→right.
  - Undefined: left channel only, as in Operation. The right shift register and adder are not built.

## Test plan
- **Reset:** hold rst for 5 clk with bck toggling → uart_tx = 1, fifo_level = 0, overflow = 0, no sample_strobe.
- **Single left sample:** send left word 0x1234 and right 0xFFFF at bck = 1.728 MHz (54 kHz frame, 16 bits per slot) for one frame plus a trailing boundary → one strobe, and UART frame 0, then bits of 0x92, then 1 with 234-cycle bits.
- **Sign conversion:** left 0x8000 → byte 0x00; left 0x7FFF → byte 0xFF; left 0x0000 → byte 0x80.
- **Overflow:** send 20 consecutive frames faster than UART drains → fifo_level saturates at 16, overflow = 1 and stays set; the bytes received are the first samples in order, with no corruption.
- **Gating:** capture_en = 0 for 3 frames → no strobe and no UART activity. After re-enable, the next valid frame is transmitted.
- **Partial slot:** the first slot after reset starts mid-word → it is discarded; the next full left word is transmitted. With I2S_UPLINK_STEREO_MIX_EN, L = 0x4000 and R = 0x2000 → byte 0x30 XOR 0x80 = 0xB0.
